// File: rtl/playback_controller_pkg.sv
// Shared constants for the playback controller.
// Speed limits, output widths and debouncer state encoding.
package playback_controller_pkg;
  localparam int SPEED_W = 8;
  localparam int FC_W = 16;
  localparam logic [SPEED_W-1:0] SPEED_MIN = 8'd1;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 8'd6;
  localparam logic [SPEED_W-1:0] SPEED_RESET = 8'd3;

  typedef enum logic {
    IDLE_LOW = 1'b0,
    IDLE_HIGH = 1'b1
  } deb_state_t;
endpackage

// File: rtl/playback_controller_button_debouncer.sv
// Raw button -> 2-FF sync -> debounce -> one-cycle press pulse.
// The debounced level flips after DEBOUNCE_CYCLES disagreeing cycles.
module button_debouncer
  import playback_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync;
  deb_state_t state;
  logic [CW-1:0] cnt;
  logic prev;
  logic lvl;

  assign lvl = (state == IDLE_HIGH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
      state <= IDLE_LOW;
      cnt <= '0;
      prev <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt <= '0;
        state <= sync[1] ? IDLE_HIGH : IDLE_LOW;
      end else begin
        cnt <= cnt + 1'b1;
      end
      prev <= lvl;
      press <= lvl & ~prev;
    end
  end
endmodule

// File: rtl/playback_controller.sv
// Buttons to speed / play-pause / pattern control for the animation path.
// Define PLAYBACK_AUTO_CYCLE_EN to auto-advance the pattern every N frames.
module playback_controller
  import playback_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_PATTERNS = 4,
  parameter int FRAMES_PER_PATTERN = 256,
  parameter int PAT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_play,
  input  logic btn_next,
  input  logic next_frame,
  output logic [SPEED_W-1:0] speed,
  output logic pause,
  output logic resume,
  output logic playing,
  output logic [PAT_W-1:0] pattern_sel,
  output logic [FC_W-1:0] frame_count
);
`ifdef PLAYBACK_AUTO_CYCLE_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PATTERN - 1);

  logic up_p, down_p, play_p, next_p;
  logic auto_adv;
  logic [PAT_W-1:0] pat_inc;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst(rst), .raw(btn_up), .press(up_p)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst(rst), .raw(btn_down), .press(down_p)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
    .clk(clk), .rst(rst), .raw(btn_play), .press(play_p)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .raw(btn_next), .press(next_p)
  );

  assign auto_adv = AUTO_EN & next_frame & playing
                  & (frame_count == FC_LAST);
  assign pat_inc = (pattern_sel == PAT_LAST) ? '0
                 : pattern_sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed <= SPEED_RESET;
      pause <= 1'b0;
      resume <= 1'b0;
      playing <= 1'b1;
      pattern_sel <= '0;
      frame_count <= '0;
    end else begin
      pause <= 1'b0;
      resume <= 1'b0;
      if (up_p && !down_p && speed != SPEED_MAX)
        speed <= speed + 1'b1;
      else if (down_p && !up_p && speed != SPEED_MIN)
        speed <= speed - 1'b1;
      // Frame is judged against the pre-toggle playing value.
      if (play_p) begin
        playing <= ~playing;
        pause <= playing;
        resume <= ~playing;
      end
      if (next_p || auto_adv) begin
        pattern_sel <= pat_inc;
        frame_count <= '0;
      end else if (next_frame && playing && frame_count != '1) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_playback_controller.sv
// Randomized bench for playback_controller against a behavioural model.
// Build with +define+PLAYBACK_AUTO_CYCLE_EN to cover auto-advance.
module tb_playback_controller;
  localparam int DB = 4;
  localparam int NP = 4;
  localparam int FPP = 3;
`ifdef PLAYBACK_AUTO_CYCLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_up, btn_down, btn_play, btn_next;
  logic next_frame;
  logic [7:0] speed;
  logic pause, resume, playing;
  logic [3:0] pattern_sel;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  int m_speed, m_pat, m_fc;
  bit m_play, m_pause, m_resume;

  playback_controller #(
    .DEBOUNCE_CYCLES(DB),
    .NUM_PATTERNS(NP),
    .FRAMES_PER_PATTERN(FPP),
    .PAT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down),
    .btn_play(btn_play), .btn_next(btn_next),
    .next_frame(next_frame),
    .speed(speed), .pause(pause), .resume(resume),
    .playing(playing), .pattern_sel(pattern_sel),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mreset();
    m_speed = 3; m_pat = 0; m_fc = 0;
    m_play = 1; m_pause = 0; m_resume = 0;
  endtask

  task automatic mstep(bit u, bit d, bit p, bit n, bit f);
    bit adv;
    m_pause = 0;
    m_resume = 0;
    if (u && !d && m_speed < 6) m_speed++;
    else if (d && !u && m_speed > 1) m_speed--;
    adv = n || (AUTO && f && m_play && m_fc == FPP - 1);
    if (adv) begin
      m_pat = (m_pat + 1) % NP;
      m_fc = 0;
    end else if (f && m_play && m_fc < 65535) begin
      m_fc++;
    end
    if (p) begin
      m_pause = m_play;
      m_resume = !m_play;
      m_play = !m_play;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".speed"}, int'(speed), m_speed);
    chk({tag, ".playing"}, int'(playing), int'(m_play));
    chk({tag, ".pat"}, int'(pattern_sel), m_pat);
    chk({tag, ".fc"}, int'(frame_count), m_fc);
  endtask

  task automatic check_pulses(string tag, bit ep, bit er);
    chk({tag, ".pause"}, int'(pause), int'(ep));
    chk({tag, ".resume"}, int'(resume), int'(er));
  endtask

  // Clean press: pulse lands 7 cycles after the rise, outputs one later.
  task automatic press(bit u, bit d, bit p, bit n, bit f);
    int hold;
    hold = $urandom_range(9, 14);
    btn_up = u; btn_down = d; btn_play = p; btn_next = n;
    repeat (7) tick();
    check_pulses("pre", 1'b0, 1'b0);
    next_frame = f;
    tick();
    next_frame = 1'b0;
    mstep(u, d, p, n, f);
    check_pulses("press", m_pause, m_resume);
    check_all("press");
    tick();
    check_pulses("after", 1'b0, 1'b0);
    repeat (hold - 9) tick();
    btn_up = 0; btn_down = 0; btn_play = 0; btn_next = 0;
    repeat (10) tick();
    check_all("rel");
  endtask

  task automatic frames(int cnt);
    for (int k = 0; k < cnt; k++) begin
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      mstep(0, 0, 0, 0, 1);
      check_all("frame");
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic bounce(int which);
    for (int k = 0; k < 5; k++) begin
      case (which)
        0: btn_up = 1;
        1: btn_down = 1;
        2: btn_play = 1;
        default: btn_next = 1;
      endcase
      repeat (2) tick();
      btn_up = 0; btn_down = 0; btn_play = 0; btn_next = 0;
      repeat (2) tick();
    end
    repeat (10) tick();
    check_all("bounce");
    check_pulses("bounce", 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    btn_up = 0; btn_down = 0; btn_play = 0; btn_next = 0;
    next_frame = 0;
    mreset();
    repeat (3) tick();
    check_all("rst");
    check_pulses("rst", 1'b0, 1'b0);
    rst = 1'b0;
    repeat (20) tick();
    check_all("idle");
    check_pulses("idle", 1'b0, 1'b0);

    repeat (5) press(1, 0, 0, 0, 0);
    chk("speed_ceiling", int'(speed), 6);
    repeat (6) press(0, 1, 0, 0, 0);
    chk("speed_floor", int'(speed), 1);

    bounce(0);
    press(1, 1, 0, 0, 0);

    press(0, 0, 1, 0, 0);
    frames(3);
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 1);
    press(0, 0, 1, 0, 1);

    repeat (5) press(0, 0, 0, 1, 0);
    press(0, 0, 0, 1, 1);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: press($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1));
        1: bounce($urandom_range(0, 3));
        default: frames($urandom_range(1, 5));
      endcase
    end

    btn_up = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #2;
    mreset();
    check_all("rst_mid");
    check_pulses("rst_mid", 1'b0, 1'b0);
    btn_up = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    check_all("rst_clean");
    check_pulses("rst_clean", 1'b0, 1'b0);

    frames(3);
    chk("auto_pat", int'(pattern_sel), AUTO ? 1 : 0);
    chk("auto_fc", int'(frame_count), AUTO ? 0 : 3);
    frames(2);
    press(0, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
